uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: deserialises an asynchronous 8N1-style serial line into parallel bytes.
- Sits directly downstream of the baud-rate tick generator. Consumes its one-cycle sampling tick, which runs at 16x the bit rate.
- Presents each received word with a one-cycle done strobe and a framing-error flag to the next stage (interface/ALU control logic).

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal 5..8), LSB transmitted first.
- SB_TICKS, 16, sampling ticks counted from the middle of the last data bit to the stop-bit sample point (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  reset, synchronous, active-high.
- i_s_tick  input  1  oversampling tick from the baud-rate generator, 1 cycle wide, 16 per bit.
- i_rx  input  1  serial line, idle high, asynchronous to i_clk.
- o_data  output  DATA_BITS  last received word.
- o_rx_done_tick  output  1  one-cycle strobe: o_data/o_frame_error just updated.
- o_frame_error  output  1  stop bit sampled low for the last frame.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are i_clk and i_reset.
- Input sync: i_rx passes through a 2-FF synchroniser (rx_s), both stages reset to 1. rx_s lags i_rx by 2 clocks.
- Reset values: FSM = IDLE, tick counter s_cnt = 0, bit counter n = 0, shift reg = 0, o_data = 0, o_rx_done_tick = 0, o_frame_error = 0, o_busy = 0.
- s_cnt is 6 bits wide; n is 3 bits wide; the shift register is DATA_BITS wide.
- IDLE:
  - rx_s == 0 on any clock (tick not required) -> START, s_cnt <= 0.
- START (only advances on i_s_tick):
  - s_cnt == 7 and rx_s == 0 -> DATA, s_cnt <= 0, n <= 0.
  - s_cnt == 7 and rx_s == 1 -> IDLE. This is a false start/glitch: no strobe, outputs unchanged.
  - Otherwise s_cnt++.
- DATA (only on i_s_tick):
  - s_cnt == 15 -> s_cnt <= 0, shift <= {rx_s, shift[DATA_BITS-1:1]}.
  - Then, if n == DATA_BITS-1 -> STOP; else n++.
  - Otherwise s_cnt++.
- STOP (only on i_s_tick):
  - s_cnt == SB_TICKS-1 -> IDLE, and in the same edge: o_data <= shift, o_frame_error <= ~rx_s, o_rx_done_tick <= 1.
  - Otherwise s_cnt++.
- o_rx_done_tick:
  - High for exactly one i_clk cycle per completed frame, including frames with a framing error.
  - Deasserted on the next clock.
- o_data and o_frame_error hold their values until the next completed frame or reset.
- Without i_s_tick, START/DATA/STOP hold state and counters indefinitely.
- A new start bit is accepted on the first clock after returning to IDLE. Back-to-back frames need no idle gap beyond the stop-bit sample point.
- i_s_tick coinciding with i_reset: reset wins.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The partial frame is discarded.
- Total latency: the strobe is asserted ((DATA_BITS*16)+8+SB_TICKS) ticks after the start-bit falling edge reaches rx_s, +1 clock for the output register.

Test Plan:
Bench drives i_s_tick every 16 clocks (bit time = 256 clocks) with DATA_BITS=8 and SB_TICKS=16, unless stated.
- Send 0x55 with a valid stop bit -> exactly one o_rx_done_tick pulse, o_data=0x55, o_frame_error=0. o_busy falls the same cycle the strobe rises.
- Send 0xA3 then 0x0F back-to-back (next start bit immediately after the stop bit) -> two strobes, o_data=0xA3 then 0x0F, no framing errors.
- Drive i_rx low for 64 clocks (4 ticks), then high -> o_busy high briefly, then back to 0. No strobe; o_data unchanged.
- Send 0xFF with the stop bit held low -> one strobe, o_data=0xFF, o_frame_error=1. Next clean frame 0x12 -> o_frame_error=0.
- Assert i_reset for 1 clock during data bit 3 of a frame -> all outputs 0 the next clock, no strobe. A following clean 0x3C is received correctly.
- Tie i_s_tick=0 and drive i_rx low -> o_busy=1, FSM stays in START, no strobe. Releasing ticks resumes reception.
- Run with SB_TICKS=32 on 0x81 -> strobe occurs 16 ticks later than with SB_TICKS=16, o_data=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled serial line to parallel words, 8N1-style framing.
// Strobe lands (DATA_BITS*16 + 8 + SB_TICKS) ticks after the start edge reaches rx_s, plus one clock.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_s_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done_tick,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic [5:0]           s_cnt_q;
  logic [2:0]           n_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_cnt_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          // Re-check the line half a bit in so a short glitch is not taken as a frame.
          if (i_s_tick) begin
            if (s_cnt_q == 6'd7) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_cnt_q <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 6'd1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (s_cnt_q == 6'd15) begin
              s_cnt_q <= '0;
              shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              if (n_q == 3'(DATA_BITS - 1)) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 3'd1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 6'd1;
            end
          end
        end
        STOP: begin
          if (i_s_tick) begin
            if (s_cnt_q == 6'(SB_TICKS - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              data_q  <= shift_q;
              ferr_q  <= ~rx_s_q;
              done_q  <= 1'b1;
            end else begin
              s_cnt_q <= s_cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data         = data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_error  = ferr_q;
  assign o_busy         = busy_q;

endmodule
